// File: rtl/poly_eval_arbiter.sv
// rtl/poly_eval_arbiter.sv - round-robin shared Horner evaluator for a cubic polynomial
module poly_eval_arbiter #(
    parameter int W     = 16,
    parameter int N_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [W-1:0]       cfg_data,
    output logic               cfg_err,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] x_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       value,
    output logic               busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           step_q, step_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         x_q, x_d;
    logic [3:0][W-1:0]    coef_q, coef_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [W-1:0]         value_q, value_d;
    logic [IW-1:0]        last_q, last_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 found;
    int                   idx;
    int                   win;
    logic [W-1:0]         step_coef;

    // Round-robin scan starting one past the previous winner.
    always_comb begin
        found = 1'b0;
        idx   = 0;
        win   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        case (step_q)
            2'd0:    step_coef = coef_q[2];
            2'd1:    step_coef = coef_q[1];
            default: step_coef = coef_q[0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        acc_d     = acc_q;
        x_d       = x_q;
        coef_d    = coef_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        value_d   = value_q;
        last_d    = last_q;
        cfg_err_d = cfg_we && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // A config write takes the cycle; any pending request waits.
                if (cfg_we) begin
                    coef_d[cfg_sel] = cfg_data;
                end else if (found) begin
                    x_d        = x_in[win*W +: W];
                    acc_d      = coef_q[3];
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    last_d     = IW'(win);
                    step_d     = 2'd0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                acc_d  = acc_q * x_q + step_coef;
                step_d = step_q + 2'd1;
                if (step_q == 2'd2) state_d = S_DONE;
            end
            S_DONE: begin
                value_d = acc_q;
                done_d  = gnt_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= 2'd0;
            acc_q     <= '0;
            x_q       <= '0;
            coef_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            value_q   <= '0;
            last_q    <= IW'(N_REQ - 1);
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            coef_q    <= coef_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            value_q   <= value_d;
            last_q    <= last_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign value   = value_q;
    assign cfg_err = cfg_err_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// tb/tb_poly_eval_arbiter.sv - directed vector bench for poly_eval_arbiter
module tb_poly_eval_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic        cfg_err;
    logic [2:0]  req;
    logic [47:0] x_in;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] value;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [2:0] grants [4];

    poly_eval_arbiter #(.W(16), .N_REQ(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .req(req), .x_in(x_in), .gnt(gnt), .done(done), .value(value), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a0, a1, a2, a3;
        int          ri;
        logic [15:0] x;
        logic [15:0] exp_val;
        string       name;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; x_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load(input logic [15:0] a0, a1, a2, a3);
        cfg_write(2'd0, a0);
        cfg_write(2'd1, a1);
        cfg_write(2'd2, a2);
        cfg_write(2'd3, a3);
    endtask

    // Waits for done; exp_lat counts negedges from the call. Drops the request on done.
    task automatic wait_done(input int ri, input logic [15:0] exp_val, input int exp_lat, input string name);
        int k;
        k = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done != 3'b000) begin
                k = n;
                break;
            end
        end
        check({name, " latency"}, k, exp_lat);
        check({name, " done"}, done, 3'b001 << ri);
        check({name, " value"}, value, exp_val);
        req[ri] = 1'b0;
    endtask

    task automatic run_eval(input int ri, input logic [15:0] xv, input logic [15:0] exp_val, input string name);
        @(negedge clk);
        x_in[ri*16 +: 16] = xv;
        req[ri] = 1'b1;
        @(negedge clk);
        check({name, " gnt"}, gnt, 3'b001 << ri);
        check({name, " busy"}, busy, 1'b1);
        wait_done(ri, exp_val, 4, name);
    endtask

    task automatic collect(input logic [2:0] rq, input int n);
        logic [2:0] prev;
        int got;
        prev = '0;
        got = 0;
        for (int i = 0; i < 4; i++) grants[i] = '0;
        @(negedge clk);
        x_in = {16'd1, 16'd1, 16'd1};
        req = rq;
        for (int c = 0; c < 60 && got < n; c++) begin
            @(negedge clk);
            if (gnt != 3'b000 && prev == 3'b000) begin
                grants[got] = gnt;
                got++;
            end
            prev = gnt;
        end
        req = '0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'd1, 16'd2, 16'd3, 16'd4, 0, 16'd2, 16'd49, "v0_x2"};
        vecs[1] = '{16'd1, 16'd2, 16'd3, 16'd4, 0, 16'd0, 16'd1, "v1_x0"};
        vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd1, 1, 16'd41, 16'd3385, "v2_wrap_cube"};
        vecs[3] = '{16'd65535, 16'd0, 16'd0, 16'd0, 2, 16'd1234, 16'd65535, "v3_const"};
        vecs[4] = '{16'd1, 16'd1, 16'd1, 16'd1, 2, 16'd3, 16'd40, "v4_ones"};
        vecs[5] = '{16'd0, 16'd0, 16'd1, 16'd0, 1, 16'd300, 16'd24464, "v5_wrap_sq"};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; req = '0; x_in = '0;
        do_reset();
        @(negedge clk);
        check("reset gnt", gnt, 0);
        check("reset done", done, 0);
        check("reset value", value, 0);
        check("reset busy", busy, 0);
        check("reset cfg_err", cfg_err, 0);

        collect(3'b111, 4);
        check("rr grant0", grants[0], 3'b001);
        check("rr grant1", grants[1], 3'b010);
        check("rr grant2", grants[2], 3'b100);
        check("rr grant3", grants[3], 3'b001);

        do_reset();
        collect(3'b101, 2);
        check("rr02 grant0", grants[0], 3'b001);
        check("rr02 grant1", grants[1], 3'b100);

        for (int i = 0; i < 6; i++) begin
            load(vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            run_eval(vecs[i].ri, vecs[i].x, vecs[i].exp_val, vecs[i].name);
        end

        // Config write collides with a request: write wins, grant one cycle later.
        load(16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 16'd7;
        x_in[16 +: 16] = 16'd2; req[1] = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        check("collide no gnt", gnt, 3'b000);
        @(negedge clk);
        check("collide gnt", gnt, 3'b010);
        wait_done(1, 16'd55, 4, "collide");

        // Config write while busy is rejected.
        load(16'd1, 16'd2, 16'd3, 16'd4);
        @(negedge clk);
        x_in[0 +: 16] = 16'd2; req[0] = 1'b1;
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 16'd99;
        @(negedge clk);
        cfg_we = 1'b0;
        check("busy cfg_err pulse", cfg_err, 1'b1);
        @(negedge clk);
        check("busy cfg_err clear", cfg_err, 1'b0);
        wait_done(0, 16'd49, 2, "busy_wr");
        run_eval(0, 16'd1, 16'd10, "busy_wr_coef_kept");

        // x_in change and req drop during CALC have no effect.
        @(negedge clk);
        x_in[16 +: 16] = 16'd3; req[1] = 1'b1;
        @(negedge clk);
        x_in[16 +: 16] = 16'd100;
        @(negedge clk);
        req[1] = 1'b0;
        wait_done(1, 16'd142, 3, "operand");

        // Reset mid-CALC.
        @(negedge clk);
        x_in[0 +: 16] = 16'd2; req[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst gnt", gnt, 0);
        check("midrst done", done, 0);
        check("midrst busy", busy, 0);
        check("midrst value", value, 0);
        @(negedge clk);
        rst_n = 1'b1; req = '0;
        run_eval(2, 16'd5, 16'd0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_eval_arbiter.md
Name: poly_eval_arbiter

Overview:
- Shared, multi-cycle evaluator for the cubic f(x) = a_0 + a_1*x + a_2*x^2 + a_3*x^3.
- Replaces the parallel combinational polynomial instances in the integration FSM with one Horner datapath.
- The datapath is time-multiplexed between N_REQ requesters (the sample points x_1..x_3) under round-robin arbitration.
- Coefficients are loaded through a configuration write port before evaluation.

Parameters:
W, 16, data width of coefficients, x and result (all arithmetic is modulo 2^W)
N_REQ, 3, number of requesters

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  coefficient write strobe
cfg_sel  input  2  coefficient index 0..3 (a_0..a_3)
cfg_data  input  W  coefficient value
cfg_err  output  1  one-cycle pulse: write rejected because block busy
req  input  N_REQ  per-requester request level
x_in  input  N_REQ*W  requester i operand at bits [i*W +: W]
gnt  output  N_REQ  one-hot owner of datapath, held while busy
done  output  N_REQ  one-hot, one-cycle result-valid pulse to owner
value  output  W  result, valid when any done bit high, held until next done
busy  output  1  high in CALC and DONE states

Behaviour:
- Reset (async, rst_n low): state=IDLE; coefficients a_0..a_3=0; gnt=0; done=0; value=0; busy=0; cfg_err=0; rr pointer last=N_REQ-1, so requester 0 has highest first priority.
- Reset mid-operation aborts the evaluation: no done is issued and coefficients are cleared.
- States: IDLE, CALC, DONE. A step counter runs 0..2 in CALC.
- IDLE:
  - cfg_we high: write cfg_data into a_[cfg_sel]; no grant that cycle, and pending req waits. Config has priority over a simultaneous req.
  - Else if any req bit high: grant the first set bit scanning from (last+1) mod N_REQ upward with wrap.
  - On grant, latch x = x_in slice of the winner, set acc=a_3, gnt=one-hot(winner), last=winner, step=0, go to CALC.
- CALC, one Horner step per cycle:
  - step0: acc = acc*x + a_2
  - step1: acc = acc*x + a_1
  - step2: acc = acc*x + a_0, go to DONE
  - Products and sums are truncated to W bits, unsigned.
- DONE (one cycle): value=acc, done=gnt, busy=1. Next edge: gnt=0, state=IDLE.
  - req is not sampled in DONE.
- Latency: req sampled at edge E in IDLE -> done high in cycle after edge E+4. Datapath is reoccupied at the earliest at edge E+5.
- Requester handshake:
  - Hold req high and x_in stable until its done is seen.
  - Deassert req at the edge where done is high, or keep it high to request again. In that case it re-enters arbitration in the next IDLE cycle.
  - x_in is only sampled at grant; changes during CALC have no effect.
  - Dropping req during CALC does not abort; done is still issued.
- cfg_we while busy: write ignored, coefficients unchanged, cfg_err pulses for one cycle.
- cfg_sel values are 2 bits, so all values are valid.
- With N_REQ=1 the arbiter always grants requester 0.
- Round-robin guarantees each continuously-requesting requester is served within N_REQ grants.
- value retains the last result after done until overwritten; it is not cleared in IDLE.

Test Plan:
- Load a_0=1, a_1=2, a_2=3, a_3=4; req[0] with x=2 -> done[0] pulses 4 edges after the req sample edge, value=49, gnt=001 during CALC/DONE. Same with x=0 -> value=1.
- Wrap-around: a_3=1, others 0; x=41 -> value=3385 (68921 mod 65536). a_0=65535, others 0, any x -> value=65535.
- Arbitration: after reset, all three req high and held -> grants in order 0,1,2,0. Then only req[0] and req[2] high with last=2 -> grants 0 then 2.
- Config collision: cfg_we high (a_0=7) in the same IDLE cycle as req[1] -> a_0 updated, grant delayed one cycle, result uses a_0=7. cfg_we while busy -> cfg_err pulse, coefficient unchanged, done/value unaffected.
- Operand stability: change x_in[1] during CALC -> value computed from the grant-time x. Drop req[1] mid-CALC -> done[1] still pulses.
- Reset mid-CALC: pull rst_n low at step1 -> gnt, done, busy, value, and coefficients all 0 immediately. After release, a new req with a_3..a_0=0 -> value=0.
